// File: rtl/tc_pl_cap_acp_if.sv
// tc_pl_cap_acp_if: bundles the record input handshake and the ACP write port of the
// capture stage.
//   Gc_merge_data/Gc_mereg_datv/Gc_mereg_datr : 56-bit merged record, valid/ready.
//   acp0_tx_en/acp0_tx_rdy                    : burst start strobe / port can accept burst.
//   acp0_tx_awaddr/acp0_tx_awid               : burst byte address / transaction ID.
//   acp0_tx_wdata/acp0_tx_wdreq               : head-of-FIFO beat data / beat pop request.
// Modports: master = capture block (drives ACP side, ready on record side);
//           slave  = environment (merge unit + ACP port).
interface tc_pl_cap_acp_if;
    logic [55:0] Gc_merge_data;
    logic        Gc_mereg_datv;
    logic        Gc_mereg_datr;
    logic        acp0_tx_en;
    logic        acp0_tx_rdy;
    logic [31:0] acp0_tx_awaddr;
    logic [2:0]  acp0_tx_awid;
    logic [63:0] acp0_tx_wdata;
    logic        acp0_tx_wdreq;

    modport master (
        input  Gc_merge_data, Gc_mereg_datv, acp0_tx_rdy, acp0_tx_wdreq,
        output Gc_mereg_datr, acp0_tx_en, acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata
    );

    modport slave (
        output Gc_merge_data, Gc_mereg_datv, acp0_tx_rdy, acp0_tx_wdreq,
        input  Gc_mereg_datr, acp0_tx_en, acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata
    );
endinterface

// File: rtl/tc_pl_cap_acp.sv
// tc_pl_cap_acp: capture-to-memory stage. Tags 56-bit records with an 8-bit sequence
// number, buffers the 64-bit words in a first-word-fall-through FIFO and writes them as
// BURST_LEN-beat bursts into a ring buffer through the ACP write port. irq_wrap pulses
// for one cycle after the burst that wraps the ring pointer back to 0.
// Ports:
//   clk125, rst     : clock, asynchronous active-high reset
//   cfg_en          : capture enable (level); rising edge restarts ptr/seq/sts_bursts
//   cfg_base        : ring base byte address; cfg_bursts : ring size in bursts (0 -> 1)
//   bus             : record handshake + ACP write port (tc_pl_cap_acp_if.master)
//   irq_wrap        : ring wrap pulse
//   sts_fill        : FIFO occupancy; sts_bursts : completed bursts since cfg_en rose
// Optional feature: define CAP_ACP_FLUSH_EN to flush a partial burst (padded with zero
// beats) when capture is disabled, instead of discarding the residual words.
module tc_pl_cap_acp #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [2:0]  ACP_ID     = 3'd0
) (
    input  logic                         clk125,
    input  logic                         rst,
    input  logic                         cfg_en,
    input  logic [31:0]                  cfg_base,
    input  logic [15:0]                  cfg_bursts,
    tc_pl_cap_acp_if.master              bus,
    output logic                         irq_wrap,
    output logic [$clog2(FIFO_DEPTH):0]  sts_fill,
    output logic [31:0]                  sts_bursts
);

    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned FillW     = PtrW + 1;
    localparam int unsigned BeatW     = $clog2(BURST_LEN);
    localparam int unsigned AddrShift = $clog2(BURST_LEN * 8);

`ifdef CAP_ACP_FLUSH_EN
    typedef enum logic [1:0] {StIdle, StAddr, StData, StPad} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
`endif

    state_e             r_state, w_state_nxt;
    logic               r_en_q;
    logic [7:0]         r_seq;
    logic [63:0]        r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [FillW-1:0]   r_fill;
    logic [BeatW-1:0]   r_beat;
    logic [15:0]        r_ptr, r_last_ptr;
    logic [31:0]        r_awaddr;
    logic               r_irq;
    logic [31:0]        r_bursts;

    logic               w_en_rise, w_datr, w_push, w_pop, w_in_phase, w_last_beat, w_clear;
    logic [7:0]         w_seq;
    logic [31:0]        w_addr;
    logic [15:0]        w_last_ptr;

`ifdef CAP_ACP_FLUSH_EN
    logic               r_flush;
    logic               w_flush_set;
`endif

    assign w_en_rise = cfg_en & ~r_en_q;
    assign w_datr    = cfg_en && (r_fill < FillW'(FIFO_DEPTH));
    assign w_push    = bus.Gc_mereg_datv && w_datr;
    // A push in the same cycle as the enable edge already uses the restarted sequence.
    assign w_seq     = w_en_rise ? 8'd0 : r_seq;

`ifdef CAP_ACP_FLUSH_EN
    assign w_in_phase = (r_state == StData) || (r_state == StPad);
    assign w_clear    = 1'b0;
`else
    assign w_in_phase = (r_state == StData);
    // Residual partial burst is dropped once idle with capture disabled.
    assign w_clear    = (r_state == StIdle) && !cfg_en && (r_fill != '0);
`endif

    // Pops on an empty FIFO are ignored; the beat counter still advances so PAD works.
    assign w_pop       = (r_state == StData) && bus.acp0_tx_wdreq && (r_fill != '0);
    assign w_last_beat = w_in_phase && bus.acp0_tx_wdreq && (r_beat == BeatW'(BURST_LEN - 1));

    assign w_addr     = cfg_base + (32'(r_ptr) << AddrShift);
    assign w_last_ptr = (cfg_bursts == 16'd0) ? 16'd0 : cfg_bursts - 16'd1;

    always_comb begin
        w_state_nxt = r_state;
`ifdef CAP_ACP_FLUSH_EN
        w_flush_set = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if ((r_fill >= FillW'(BURST_LEN)) && bus.acp0_tx_rdy) begin
                    w_state_nxt = StAddr;
                end
`ifdef CAP_ACP_FLUSH_EN
                else if (!cfg_en && (r_fill != '0) && bus.acp0_tx_rdy) begin
                    w_state_nxt = StAddr;
                    w_flush_set = 1'b1;
                end
`endif
            end
            StAddr: w_state_nxt = StData;
            StData: begin
                if (w_last_beat) begin
                    w_state_nxt = StIdle;
                end
`ifdef CAP_ACP_FLUSH_EN
                // Last real word of a flush burst leaves; remaining beats are zero filler.
                else if (r_flush && w_pop && (r_fill == FillW'(1))) begin
                    w_state_nxt = StPad;
                end
`endif
            end
`ifdef CAP_ACP_FLUSH_EN
            StPad: begin
                if (w_last_beat) begin
                    w_state_nxt = StIdle;
                end
            end
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    // FIFO storage has no reset; sts_fill gates the visible head word.
    always_ff @(posedge clk125) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_seq, bus.Gc_merge_data};
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_seq    <= 8'd0;
        end else if (w_clear) begin
            r_rd_ptr <= r_wr_ptr;
            r_fill   <= '0;
        end else begin
            r_seq <= w_push ? w_seq + 8'd1 : w_seq;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - 1'b1;
            end
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_en_q     <= 1'b0;
            r_beat     <= '0;
            r_ptr      <= 16'd0;
            r_last_ptr <= 16'd0;
            r_awaddr   <= 32'd0;
            r_irq      <= 1'b0;
            r_bursts   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_en_q  <= cfg_en;
            r_irq   <= 1'b0;
            if (r_state == StAddr) begin
                r_awaddr   <= w_addr;
                r_last_ptr <= w_last_ptr;
                r_beat     <= '0;
            end else if (w_in_phase && bus.acp0_tx_wdreq) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_en_rise) begin
                r_ptr    <= 16'd0;
                r_bursts <= 32'd0;
            end else if (w_last_beat) begin
                r_bursts <= r_bursts + 32'd1;
                if (r_ptr == r_last_ptr) begin
                    r_ptr <= 16'd0;
                    r_irq <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 16'd1;
                end
            end
        end
    end

`ifdef CAP_ACP_FLUSH_EN
    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            r_flush <= 1'b0;
        end else if (w_flush_set) begin
            r_flush <= 1'b1;
        end else if (w_last_beat) begin
            r_flush <= 1'b0;
        end
    end
`endif

    assign bus.Gc_mereg_datr  = w_datr;
    assign bus.acp0_tx_en     = (r_state == StAddr);
    // Address is live during ADDR and held afterwards until the next burst.
    assign bus.acp0_tx_awaddr = (r_state == StAddr) ? w_addr : r_awaddr;
    assign bus.acp0_tx_awid   = ACP_ID;
    assign bus.acp0_tx_wdata  = (r_fill != '0) ? r_mem[r_rd_ptr] : 64'd0;
    assign irq_wrap           = r_irq;
    assign sts_fill           = r_fill;
    assign sts_bursts         = r_bursts;

endmodule

// File: tb/tb_tc_pl_cap_acp.sv
module tb_tc_pl_cap_acp;
    logic        clk125;
    logic        rst;
    logic        cfg_en;
    logic [31:0] cfg_base;
    logic [15:0] cfg_bursts;
    logic        irq_wrap;
    logic [6:0]  sts_fill;
    logic [31:0] sts_bursts;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] awq[$];
    logic [63:0] beats[$];
    logic [31:0] irqq[$];
    int          beats_left;
    int          n0;

    tc_pl_cap_acp_if u_if ();

    tc_pl_cap_acp u_dut (
        .clk125     (clk125),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_base   (cfg_base),
        .cfg_bursts (cfg_bursts),
        .bus        (u_if.master),
        .irq_wrap   (irq_wrap),
        .sts_fill   (sts_fill),
        .sts_bursts (sts_bursts)
    );

    initial clk125 = 1'b0;
    always #4 clk125 = ~clk125;

    // ACP-side observer: records burst addresses, beats actually popped, and wrap pulses.
    always @(negedge clk125) begin
        if (rst) begin
            beats_left <= 0;
        end else begin
            if (u_if.acp0_tx_en) begin
                awq.push_back(u_if.acp0_tx_awaddr);
                beats_left <= 16;
            end else if (beats_left > 0 && u_if.acp0_tx_wdreq) begin
                beats.push_back(u_if.acp0_tx_wdata);
                beats_left <= beats_left - 1;
            end
            if (irq_wrap) irqq.push_back(sts_bursts);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk125);
        #1;
    endtask

    task automatic push_n(input logic [55:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!u_if.Gc_mereg_datr && t < 400) begin
                u_if.Gc_mereg_datv = 1'b0;
                step();
                t++;
            end
            if (!u_if.Gc_mereg_datr) begin
                chk("push_datr", 64'(u_if.Gc_mereg_datr), 64'd1);
                u_if.Gc_mereg_datv = 1'b0;
                return;
            end
            u_if.Gc_mereg_datv = 1'b1;
            u_if.Gc_merge_data = first + 56'(i);
            step();
        end
        u_if.Gc_mereg_datv = 1'b0;
    endtask

    task automatic wait_bursts(input string tag, input int n, input int budget);
        int t = 0;
        while (sts_bursts != 32'(n) && t < budget) begin
            step();
            t++;
        end
        chk(tag, 64'(sts_bursts), 64'(n));
    endtask

    task automatic wait_en(input string tag);
        int t = 0;
        while (!u_if.acp0_tx_en && t < 200) begin
            step();
            t++;
        end
        chk(tag, 64'(u_if.acp0_tx_en), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        cfg_en = 1'b0;
        cfg_base = 32'h1000_0000;
        cfg_bursts = 16'd4;
        u_if.Gc_merge_data = 56'd0;
        u_if.Gc_mereg_datv = 1'b0;
        u_if.acp0_tx_rdy = 1'b0;
        u_if.acp0_tx_wdreq = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_en", 64'(u_if.acp0_tx_en), 64'd0);
        chk("rst_awaddr", 64'(u_if.acp0_tx_awaddr), 64'd0);
        chk("rst_awid", 64'(u_if.acp0_tx_awid), 64'd0);
        chk("rst_wdata", u_if.acp0_tx_wdata, 64'd0);
        chk("rst_irq", 64'(irq_wrap), 64'd0);
        chk("rst_fill", 64'(sts_fill), 64'd0);
        chk("rst_bursts", 64'(sts_bursts), 64'd0);
        chk("rst_datr", 64'(u_if.Gc_mereg_datr), 64'd0);
        rst = 1'b0;
        step();

        // Single burst of records 1..16
        cfg_en = 1'b1;
        u_if.acp0_tx_rdy = 1'b1;
        u_if.acp0_tx_wdreq = 1'b1;
        push_n(56'h1, 16);
        chk("t1_fill16", 64'(sts_fill), 64'd16);
        chk("t1_en_not_yet", 64'(u_if.acp0_tx_en), 64'd0);
        step();
        chk("t1_en", 64'(u_if.acp0_tx_en), 64'd1);
        chk("t1_awaddr", 64'(u_if.acp0_tx_awaddr), 64'h1000_0000);
        wait_bursts("t1_bursts", 1, 100);
        step();
        chk("t1_nbeats", 64'(beats.size()), 64'd16);
        chk("t1_beat0", beats[0], 64'h00_0000_0000_0000_01);
        chk("t1_beat15", beats[15], 64'h0F_0000_0000_0000_10);
        chk("t1_naddr", 64'(awq.size()), 64'd1);
        chk("t1_fill0", 64'(sts_fill), 64'd0);

        // 64 bursts, ring of 4
        cfg_en = 1'b0;
        step();
        step();
        cfg_en = 1'b1;
        awq.delete();
        beats.delete();
        irqq.delete();
        push_n(56'h1, 1024);
        wait_bursts("t2_bursts", 64, 3000);
        step();
        step();
        chk("t2_naddr", 64'(awq.size()), 64'd64);
        chk("t2_addr1", 64'(awq[1]), 64'h1000_0080);
        chk("t2_addr2", 64'(awq[2]), 64'h1000_0100);
        chk("t2_addr3", 64'(awq[3]), 64'h1000_0180);
        chk("t2_addr4", 64'(awq[4]), 64'h1000_0000);
        chk("t2_addr63", 64'(awq[63]), 64'h1000_0180);
        chk("t2_nirq", 64'(irqq.size()), 64'd16);
        chk("t2_irq_first", 64'(irqq[0]), 64'd4);
        chk("t2_irq_last", 64'(irqq[15]), 64'd64);
        chk("t2_beat0", beats[0], 64'h00_0000_0000_0000_01);
        chk("t2_beat255", beats[255], 64'hFF_0000_0000_0001_00);
        chk("t2_beat256", beats[256], 64'h00_0000_0000_0001_01);
        chk("t2_beat1023", beats[1023], 64'hFF_0000_0000_0004_00);

        // Back-pressure: FIFO fills to 64 while the port is not ready
        u_if.acp0_tx_rdy = 1'b0;
        push_n(56'h200, 64);
        chk("t3_fill64", 64'(sts_fill), 64'd64);
        chk("t3_datr_low", 64'(u_if.Gc_mereg_datr), 64'd0);
        step();
        step();
        step();
        chk("t3_idle_nopop", 64'(sts_fill), 64'd64);
        u_if.acp0_tx_rdy = 1'b1;
        wait_en("t3_en");
        step();
        chk("t3_datr_still_low", 64'(u_if.Gc_mereg_datr), 64'd0);
        step();
        chk("t3_datr_back", 64'(u_if.Gc_mereg_datr), 64'd1);
        chk("t3_fill63", 64'(sts_fill), 64'd63);
        wait_bursts("t3_bursts", 68, 400);
        chk("t3_fill0", 64'(sts_fill), 64'd0);

        // Simultaneous push/pop with fill=20
        u_if.acp0_tx_rdy = 1'b0;
        u_if.acp0_tx_wdreq = 1'b0;
        push_n(56'h300, 20);
        chk("t4_fill20", 64'(sts_fill), 64'd20);
        u_if.acp0_tx_rdy = 1'b1;
        wait_en("t4_en");
        u_if.acp0_tx_rdy = 1'b0;
        step();
        u_if.acp0_tx_wdreq = 1'b1;
        u_if.Gc_mereg_datv = 1'b1;
        u_if.Gc_merge_data = 56'h3FF;
        step();
        u_if.Gc_mereg_datv = 1'b0;
        chk("t4_fill_pushpop", 64'(sts_fill), 64'd20);
        wait_bursts("t4_bursts", 69, 100);
        chk("t4_fill5", 64'(sts_fill), 64'd5);

        // Capture disabled with 5 residual words
        n0 = awq.size();
        u_if.acp0_tx_rdy = 1'b1;
        cfg_en = 1'b0;
`ifdef CAP_ACP_FLUSH_EN
        wait_bursts("t5_flush_bursts", 70, 100);
        step();
        chk("t5_flush_naddr", 64'(awq.size()), 64'(n0 + 1));
        chk("t5_flush_fill", 64'(sts_fill), 64'd0);
        chk("t5_flush_last_real", beats[beats.size() - 12], 64'h54_0000_0000_0003_FF);
        chk("t5_flush_pad_first", beats[beats.size() - 11], 64'd0);
        chk("t5_flush_pad_last", beats[beats.size() - 1], 64'd0);
`else
        step();
        chk("t5_fill_cleared", 64'(sts_fill), 64'd0);
        for (int i = 0; i < 20; i++) step();
        chk("t5_no_en", 64'(awq.size()), 64'(n0));
        chk("t5_bursts", 64'(sts_bursts), 64'd69);
`endif

        // Reset in the middle of a burst
        cfg_en = 1'b1;
        u_if.acp0_tx_wdreq = 1'b0;
        step();
        chk("t6_bursts_cleared", 64'(sts_bursts), 64'd0);
        push_n(56'h400, 16);
        wait_en("t6_en");
        step();
        u_if.acp0_tx_wdreq = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("t6_fill9", 64'(sts_fill), 64'd9);
        rst = 1'b1;
        #1;
        chk("t6_rst_en", 64'(u_if.acp0_tx_en), 64'd0);
        chk("t6_rst_awaddr", 64'(u_if.acp0_tx_awaddr), 64'd0);
        chk("t6_rst_awid", 64'(u_if.acp0_tx_awid), 64'd0);
        chk("t6_rst_wdata", u_if.acp0_tx_wdata, 64'd0);
        chk("t6_rst_fill", 64'(sts_fill), 64'd0);
        chk("t6_rst_bursts", 64'(sts_bursts), 64'd0);
        step();
        rst = 1'b0;
        awq.delete();
        beats.delete();
        step();
        chk("t6_no_beats", 64'(beats.size()), 64'd0);
        push_n(56'h500, 16);
        wait_bursts("t6_restart_bursts", 1, 100);
        step();
        chk("t6_restart_addr", 64'(awq[0]), 64'h1000_0000);
        chk("t6_restart_nbeats", 64'(beats.size()), 64'd16);
        chk("t6_restart_beat0", beats[0], 64'h00_0000_0000_0005_00);
        chk("t6_restart_beat15", beats[15], 64'h0F_0000_0000_0005_0F);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tc_pl_cap_acp.md
Name: tc_pl_cap_acp

Overview:
- Capture-to-memory stage downstream of the merge unit in the Tc_PL top.
- Accepts 56-bit merged measurement records on the Gc_merge valid/ready handshake and tags each with an 8-bit sequence number to form 64-bit words.
- Buffers the words in a FIFO and writes them as fixed-length bursts into a ring buffer in PS DDR through the acp0_tx write port.
- Raises an interrupt pulse on each ring wrap.

Parameters:
- BURST_LEN, 16: 64-bit beats per ACP burst; power of 2.
- FIFO_DEPTH, 64: FIFO depth in words; power of 2, ≥ BURST_LEN.
- ACP_ID, 3'd0: constant value driven on acp0_tx_awid.

Ports:
- clk125  in  1  system clock, 125 MHz
- rst  in  1  asynchronous active-high reset
- cfg_en  in  1  capture enable (level)
- cfg_base  in  32  ring base byte address; aligned to BURST_LEN*8
- cfg_bursts  in  16  ring size in bursts; 0 is treated as 1
- Gc_merge_data  in  56  merged record
- Gc_mereg_datv  in  1  record valid
- Gc_mereg_datr  out  1  record ready
- acp0_tx_en  out  1  burst start strobe, 1 cycle
- acp0_tx_rdy  in  1  ACP port can accept a new burst
- acp0_tx_awaddr  out  32  burst byte address
- acp0_tx_awid  out  3  transaction ID
- acp0_tx_wdata  out  64  write beat data
- acp0_tx_wdreq  in  1  beat pop request from ACP port
- irq_wrap  out  1  1-cycle pulse on ring wrap
- sts_fill  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- sts_bursts  out  32  completed bursts since cfg_en rose; wraps

Behaviour:
- Reset values: all outputs 0, except acp0_tx_awid = ACP_ID. FSM = IDLE. FIFO empty. Ring pointer ptr = 0. Sequence number seq = 0.
- cfg_en rising edge (registered compare): clear ptr, seq and sts_bursts.
- Input handshake:
  - Gc_mereg_datr = cfg_en && (fill < FIFO_DEPTH); derived combinationally from registered state.
  - Push occurs when datv && datr. Pushed word = {seq, Gc_merge_data}.
  - seq increments per push and wraps 255 -> 0.
- FIFO:
  - First-word fall-through: acp0_tx_wdata always shows the head word.
  - Push and pop in the same cycle leave fill unchanged.
  - A pop on an empty FIFO is a protocol error; the block ignores it and fill stays 0.
- FSM states: IDLE, ADDR, DATA.
  - IDLE -> ADDR when fill ≥ BURST_LEN && acp0_tx_rdy.
  - ADDR (1 cycle):
    - acp0_tx_en = 1.
    - acp0_tx_awaddr = cfg_base + ptr*BURST_LEN*8; held until the next ADDR.
    - Beat counter cleared. Next state DATA.
  - DATA:
    - Each cycle with acp0_tx_wdreq pops one word and increments the beat counter.
    - On the pop with beat == BURST_LEN-1: return to IDLE, sts_bursts+1, and advance ptr.
    - ptr advance: if ptr == max(cfg_bursts,1)-1 then ptr = 0 and irq_wrap pulses the following cycle; otherwise ptr+1.
  - acp0_tx_wdreq outside DATA is ignored; no pop occurs.
- Latency: a word pushed into an empty FIFO is visible on wdata the next cycle. The earliest acp0_tx_en comes 1 cycle after fill reaches BURST_LEN.
- cfg_en falling:
  - datr drops immediately.
  - A burst already in ADDR/DATA completes normally.
  - Once back in IDLE with cfg_en low, residual words (< BURST_LEN) are discarded: the FIFO is cleared in one cycle.
- cfg_base and cfg_bursts are sampled per burst in ADDR. Software changes them only while cfg_en is low.
- A reset mid-burst aborts the burst. The ACP side then sees no further beats.

Optional Feature:
- Macro: CAP_ACP_FLUSH_EN.
- Defined: adds state PAD for flushing a partial burst.
  - Entry: in IDLE with cfg_en low, 0 < fill < BURST_LEN and acp0_tx_rdy, go to ADDR with a flush flag set.
  - The burst then runs its full BURST_LEN beats: real words first, then 64'h0 filler beats once the FIFO is empty (PAD phase, no pop).
  - ptr, sts_bursts and irq_wrap update exactly as for a normal burst.
- Undefined: residual words are discarded as described above; PAD does not exist.

Test Plan:
- Stream 16 records 0x1..0x10, acp0_tx_rdy=1, cfg_base=0x1000_0000, cfg_bursts=4, continuous wdreq -> one tx_en pulse, awaddr 0x1000_0000, wdata 0x00..01 through 0x0F..10, sts_bursts=1.
- 64 bursts with cfg_bursts=4 -> awaddr cycles 0x1000_0000 / 080 / 100 / 180; irq_wrap pulses after bursts 4, 8, …, 64 (16 pulses); seq tag wraps after word 256.
- acp0_tx_rdy=0 while 64 records arrive -> datr falls when fill=64, sts_fill=64; rdy=1 -> 4 bursts drain, datr reasserts after the first pop.
- Simultaneous push/pop with fill=20 during DATA -> fill stays 20; wdreq held high in IDLE -> no pop.
- 5 records, then cfg_en low -> without macro: fill clears to 0 and no tx_en; with CAP_ACP_FLUSH_EN: one burst of 5 data beats plus 11 beats of 64'h0, sts_bursts=1.
- rst asserted in DATA after 7 beats -> all outputs 0, awid=ACP_ID, fill=0; a new 16-record stream restarts at cfg_base with seq 0.
